// File: rtl/wb_master_ctrl.sv
// Wishbone classic single-transfer master with retry/backoff and registered outputs.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl #(
  parameter int aw             = 32,
  parameter int dw             = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [aw-1:0] req_adr,
  input  logic [dw-1:0] req_dat,
  input  logic [3:0]    req_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [dw-1:0] rsp_dat,
  output logic [1:0]    rsp_status,
  output logic          busy,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t          state, state_d;
  logic [3:0]      retry_cnt, retry_d;
  logic            req_ready_d, rsp_valid_d, busy_d, cyc_d, we_d;
  logic [dw-1:0]   rsp_dat_d, wdat_d;
  logic [1:0]      status_d;
  logic [aw-1:0]   adr_d;
  logic [3:0]      sel_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [1:0]  ST_TMO   = 2'b11;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt, tmo_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
      busy       <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      state      <= state_d;
      retry_cnt  <= retry_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_dat    <= rsp_dat_d;
      rsp_status <= status_d;
      busy       <= busy_d;
      wb_cyc_o   <= cyc_d;
      wb_stb_o   <= cyc_d;
      wb_we_o    <= we_d;
      wb_adr_o   <= adr_d;
      wb_dat_o   <= wdat_d;
      wb_sel_o   <= sel_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt    <= tmo_d;
`endif
    end
  end

  // Next-state logic computes the value every output register takes at the next edge.
  always_comb begin
    state_d     = state;
    retry_d     = retry_cnt;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
    status_d    = rsp_status;
    cyc_d       = wb_cyc_o;
    we_d        = wb_we_o;
    adr_d       = wb_adr_o;
    wdat_d      = wb_dat_o;
    sel_d       = wb_sel_o;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_d       = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = req_we;
          adr_d   = req_adr;
          wdat_d  = req_dat;
          sel_d   = req_sel;
          retry_d = '0;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = wb_we_o ? '0 : wb_dat_i;
          status_d    = ST_OK;
        end else if (wb_err_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          status_d    = ST_ERR;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (retry_cnt < RETRY_LIMIT) begin
            state_d = BACKOFF;
            if (retry_cnt != 4'hF) retry_d = retry_cnt + 4'd1;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_dat_d   = '0;
            status_d    = ST_RTY;
          end
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          status_d    = ST_TMO;
        end else begin
          tmo_d = tmo_cnt + 16'd1;
        end
`endif
      end
      BACKOFF: begin
        state_d = BUS;
        cyc_d   = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Directed self-checking bench for wb_master_ctrl (MAX_RETRY=2, TIMEOUT_CYCLES=16).
// Inputs are driven and outputs sampled on the falling edge of wb_clk.
module tb_wb_master_ctrl;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  int checks = 0;
  int errors = 0;

  wb_master_ctrl #(.aw(32), .dw(32), .MAX_RETRY(2), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one request; returns on the falling edge right after the handshake edge.
  task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel);
    @(negedge wb_clk);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
    @(negedge wb_clk);
    req_valid = 1'b0;
  endtask

  task automatic release_response();
    rsp_ready = 1'b1;
    @(negedge wb_clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [5:0] rty_pattern;
    wb_rst_n  = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0;
    wb_dat_i  = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

    #7;
    check_output("rst_cyc", wb_cyc_o, 0);
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_status", rsp_status, 0);
    check_output("rst_adr", wb_adr_o, 0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    check_output("post_rst_req_ready", req_ready, 1);

    $display("[TB] write with two wait states");
    apply_stimulus(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    check_output("wr_cyc1", wb_cyc_o, 1);
    check_output("wr_stb1", wb_stb_o, 1);
    check_output("wr_we", wb_we_o, 1);
    check_output("wr_adr", wb_adr_o, 32'h0000_0004);
    check_output("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
    check_output("wr_sel", wb_sel_o, 4'hF);
    check_output("wr_busy", busy, 1);
    check_output("wr_req_ready", req_ready, 0);
    @(negedge wb_clk);
    check_output("wr_cyc2", wb_cyc_o, 1);
    @(negedge wb_clk);
    check_output("wr_cyc3", wb_cyc_o, 1);
    wb_ack_i = 1'b1;
    @(negedge wb_clk);
    wb_ack_i = 1'b0;
    check_output("wr_cyc_drop", wb_cyc_o, 0);
    check_output("wr_stb_drop", wb_stb_o, 0);
    check_output("wr_rsp_valid", rsp_valid, 1);
    check_output("wr_status", rsp_status, 2'b00);
    check_output("wr_rsp_dat", rsp_dat, 0);
    release_response();
    check_output("wr_rsp_done", rsp_valid, 0);
    check_output("wr_req_ready_back", req_ready, 1);
    check_output("wr_busy_idle", busy, 0);

    $display("[TB] zero-wait read with response back-pressure");
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1234_5678;
    apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    check_output("rd_cyc", wb_cyc_o, 1);
    check_output("rd_we", wb_we_o, 0);
    check_output("rd_early_valid", rsp_valid, 0);
    @(negedge wb_clk);
    wb_ack_i = 1'b0;
    wb_dat_i = 32'hFFFF_FFFF;
    check_output("rd_rsp_valid_n2", rsp_valid, 1);
    check_output("rd_cyc_drop", wb_cyc_o, 0);
    for (int i = 0; i < 5; i++) begin
      check_output("rd_hold_dat", rsp_dat, 32'h1234_5678);
      check_output("rd_hold_valid", rsp_valid, 1);
      check_output("rd_hold_status", rsp_status, 2'b00);
      @(negedge wb_clk);
    end
    release_response();
    check_output("rd_req_ready_back", req_ready, 1);

    $display("[TB] retry exhaustion");
    wb_rty_i = 1'b1;
    rty_pattern = 6'b010101;
    apply_stimulus(1'b0, 32'h0000_0020, 32'h0, 4'h3);
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("rty_cyc%0d", i), wb_cyc_o, 32'(rty_pattern[i]));
      check_output($sformatf("rty_adr%0d", i), wb_adr_o, 32'h0000_0020);
      if (i < 5) @(negedge wb_clk);
    end
    wb_rty_i = 1'b0;
    check_output("rty_rsp_valid", rsp_valid, 1);
    check_output("rty_status", rsp_status, 2'b10);
    release_response();

    $display("[TB] termination priority");
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    wb_dat_i = 32'hA5A5_A5A5;
    apply_stimulus(1'b0, 32'h0000_0030, 32'h0, 4'hF);
    @(negedge wb_clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check_output("pri_ack_err_status", rsp_status, 2'b00);
    check_output("pri_ack_err_dat", rsp_dat, 32'hA5A5_A5A5);
    release_response();
    wb_err_i = 1'b1; wb_rty_i = 1'b1;
    apply_stimulus(1'b0, 32'h0000_0034, 32'h0, 4'hF);
    @(negedge wb_clk);
    wb_err_i = 1'b0; wb_rty_i = 1'b0;
    check_output("pri_err_rty_valid", rsp_valid, 1);
    check_output("pri_err_rty_status", rsp_status, 2'b01);
    check_output("pri_err_rty_dat", rsp_dat, 0);
    release_response();

    $display("[TB] silent slave");
    apply_stimulus(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    cnt = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 40 && wb_cyc_o; i++) begin
      cnt++;
      @(negedge wb_clk);
    end
    check_output("tmo_cyc_cycles", cnt, 16);
    check_output("tmo_rsp_valid", rsp_valid, 1);
    check_output("tmo_status", rsp_status, 2'b11);
    release_response();
    apply_stimulus(1'b0, 32'h0000_0050, 32'h0, 4'hF);
    repeat (3) @(negedge wb_clk);
`else
    for (int i = 0; i < 100; i++) begin
      if (wb_cyc_o) cnt++;
      @(negedge wb_clk);
    end
    check_output("notmo_cyc_cycles", cnt, 100);
    check_output("notmo_rsp_valid", rsp_valid, 0);
`endif

    $display("[TB] reset during bus cycle");
    check_output("mid_rst_cyc_before", wb_cyc_o, 1);
    #2;
    wb_rst_n = 1'b0;
    #1;
    check_output("mid_rst_cyc", wb_cyc_o, 0);
    check_output("mid_rst_stb", wb_stb_o, 0);
    check_output("mid_rst_rsp_valid", rsp_valid, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_req_ready", req_ready, 0);
    check_output("mid_rst_adr", wb_adr_o, 0);
    repeat (2) @(negedge wb_clk);
    check_output("mid_rst_held_valid", rsp_valid, 0);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    check_output("rel_req_ready", req_ready, 1);
    check_output("rel_rsp_valid", rsp_valid, 0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    apply_stimulus(1'b0, 32'h0000_0060, 32'h0, 4'hF);
    check_output("rel_cyc", wb_cyc_o, 1);
    @(negedge wb_clk);
    wb_ack_i = 1'b0;
    check_output("rel_rsp_valid_after", rsp_valid, 1);
    check_output("rel_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    release_response();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_master_ctrl.md
WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- aw, 32, address width.
- dw, 32, data width.
- MAX_RETRY, 3, retries after rty before giving up (0..15).
- TIMEOUT_CYCLES, 1024, watchdog limit in wb_clk cycles (1..65535).

REQ-002 The block SHALL have these ports:
- wb_clk  in  1  Wishbone clock; the only clock.
- wb_rst_n  in  1  Reset, asynchronous, active-low.
- req_valid  in  1  Request offered.
- req_ready  out  1  Request accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  aw  Target address.
- req_dat  in  dw  Write data.
- req_sel  in  4  Byte selects.
- rsp_valid  out  1  Response available.
- rsp_ready  in  1  Response consumed.
- rsp_dat  out  dw  Read data (0 for writes).
- rsp_status  out  2  00 OK, 01 ERR, 10 RTY exhausted, 11 TIMEOUT.
- busy  out  1  High in any state other than IDLE.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Write enable.
- wb_adr_o  out  aw  Address.
- wb_dat_o  out  dw  Write data.
- wb_sel_o  out  4  Byte selects.
- wb_dat_i  in  dw  Read data.
- wb_ack_i  in  1  Normal termination.
- wb_err_i  in  1  Error termination.
- wb_rty_i  in  1  Retry termination.

Function
REQ-003 The FSM SHALL have states IDLE, BUS, BACKOFF and RESP; all outputs SHALL be registered.
REQ-004 In IDLE, req_ready SHALL be 1; a handshake (req_valid & req_ready) at edge N SHALL latch we/adr/dat/sel, clear the retry and timeout counters, and enter BUS, with wb_cyc_o = wb_stb_o = 1 from cycle N+1.
REQ-005 In BUS, wb_cyc_o and wb_stb_o SHALL be 1, wb_we_o/adr/dat/sel SHALL hold the latched values, and req_ready SHALL be 0.
REQ-006 Termination priority SHALL be ack > err > rty when several are sampled high in the same cycle.
REQ-007 On ack, the block SHALL capture wb_dat_i into rsp_dat for reads (0 for writes), set status 00, deassert cyc/stb at the next edge, and enter RESP.
REQ-008 On err (no ack), the block SHALL set rsp_dat = 0 and status 01, and enter RESP.
REQ-009 On rty (no ack/err) with retry count < MAX_RETRY, the block SHALL increment the count and enter BACKOFF, holding cyc/stb low for exactly one cycle before returning to BUS with the same latched request.
REQ-010 On rty with retry count = MAX_RETRY, the block SHALL set status 10 and enter RESP; MAX_RETRY = 0 SHALL mean no retry.
REQ-011 The retry counter SHALL be 4 bits and saturate, never wrapping.
REQ-012 In RESP, rsp_valid SHALL be 1, and rsp_dat/rsp_status SHALL be stable until rsp_valid & rsp_ready; the block SHALL then return to IDLE, so req_ready = 1 on the next cycle.
REQ-013 Terminations sampled outside BUS SHALL be ignored.
REQ-014 Minimum latency SHALL be: request handshake at edge N, zero-wait ack at edge N+1, rsp_valid at cycle N+2.

Reset
REQ-015 Asserting wb_rst_n low SHALL immediately force state IDLE, wb_cyc_o = wb_stb_o = wb_we_o = 0, wb_adr_o/dat_o/sel_o = 0, rsp_valid = 0, rsp_dat = 0, rsp_status = 00, busy = 0, counters = 0, and req_ready = 0 while reset is held.
REQ-016 Reset asserted mid-cycle SHALL abandon the transfer with no response; after deassertion, req_ready SHALL be 1 on the first wb_clk edge.

Configuration
REQ-017 With WB_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles spent in BUS for each attempt; on reaching TIMEOUT_CYCLES without termination, the block SHALL deassert cyc/stb, set status 11, and enter RESP.
REQ-018 Without WB_MASTER_TIMEOUT_EN, the counter logic SHALL be absent, BUS SHALL wait indefinitely, and status 11 SHALL never be produced.

Verification
REQ-019 Write: adr 0x0000_0004, dat 0xDEADBEEF, sel 0xF, ack after 2 wait states -> cyc/stb high for exactly 3 cycles, outputs match, rsp_status 00, rsp_dat 0.
REQ-020 Read: adr 0x0000_0010, zero-wait ack, wb_dat_i 0x12345678 -> rsp_valid at N+2, rsp_dat 0x12345678, status 00; with rsp_ready held 0 for 5 cycles, the response stays stable.
REQ-021 Retry: MAX_RETRY = 2, slave asserts rty on every attempt -> 3 bus attempts separated by 1-cycle cyc gaps, status 10.
REQ-022 Priority: ack and err high in the same cycle -> status 00; err and rty high together -> status 01, no retry.
REQ-023 Timeout: TIMEOUT_CYCLES = 16, slave silent -> with macro, cyc drops after 16 BUS cycles and status is 11; without macro, cyc stays high for 100+ cycles.
REQ-024 Reset mid-BUS: wb_rst_n low while cyc = 1 -> cyc/stb/rsp_valid 0 immediately, no response; a new request is accepted normally after release.
